dm_arbiter: RTL and testbench

//   Round-robin arbiter that shares one single-port data memory (DM) between NUM_CORES

---
 rtl/dm_arbiter_pkg.sv | 22 ++
 rtl/dm_arbiter_if.sv | 38 +++
 rtl/dm_arbiter_rr_picker.sv | 45 ++++
 rtl/dm_arbiter.sv | 126 ++++++++++++
 tb/tb_dm_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the DM arbiter: state codes, width defaults and pointer sizing.
`default_nettype none

package dm_arbiter_pkg;

  localparam int DM_NUM_CORES = 4;
  localparam int DM_ADDR_W    = 16;
  localparam int DM_DATA_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_if.sv
// Core-request and data-memory signal bundle seen by the DM arbiter.
`default_nettype none

interface dm_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);

  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]        core_halt;
  logic [NUM_CORES-1:0]        gnt;
  logic [NUM_CORES-1:0]        done;
  logic [DATA_W-1:0]           rdata;
  logic                        all_halted;
  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  // Environment side: cores plus the BRAM.
  modport master (
    output req, we, addr, wdata, core_halt, mem_rdata,
    input  gnt, done, rdata, all_halted, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, wdata, core_halt, mem_rdata,
    output gnt, done, rdata, all_halted, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/dm_arbiter_rr_picker.sv
// Round-robin pick: first eligible index at or after ptr_i, wrapping modulo NUM_CORES.
`default_nettype none

module dm_arbiter_rr_picker
  import dm_arbiter_pkg::*;
#(
  parameter  int NUM_CORES = DM_NUM_CORES,
  localparam int PW        = ptr_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] eligible_i,
  input  logic [PW-1:0]        ptr_i,
  output logic                 any_o,
  output logic [PW-1:0]        winner_o
);

  localparam logic [PW:0] C_N = (PW+1)'(NUM_CORES);

  logic [2*NUM_CORES-1:0] dbl;
  logic [NUM_CORES-1:0]   rot;
  logic [PW-1:0]          off;
  logic                   found;
  logic [PW:0]            sum_raw;
  logic [PW:0]            sum_wrap;

  always_comb begin
    dbl   = {eligible_i, eligible_i};
    rot   = dbl[ptr_i +: NUM_CORES];
    any_o = |eligible_i;
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found && rot[i]) begin
        off   = PW'(i);
        found = 1'b1;
      end
    end
    // Explicit wrap keeps non-power-of-2 core counts in range.
    sum_raw  = {1'b0, ptr_i} + {1'b0, off};
    sum_wrap = (sum_raw >= C_N) ? (sum_raw - C_N) : sum_raw;
    winner_o = sum_wrap[PW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// Round-robin arbiter serialising core accesses onto one single-port BRAM (1-cycle read).
`default_nettype none

module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DM_NUM_CORES,
  parameter int ADDR_W    = DM_ADDR_W,
  parameter int DATA_W    = DM_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus_io
);

  localparam int PW = ptr_width(NUM_CORES);

  dm_state_e             state_q;
  logic [PW-1:0]         rr_ptr_q;
  logic [PW-1:0]         win_q;
  logic                  is_rd_q;
  logic [NUM_CORES-1:0]  gnt_q;
  logic [NUM_CORES-1:0]  done_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  all_halted_q;

  logic [NUM_CORES-1:0]  eligible;
  logic                  any;
  logic [PW-1:0]         winner;
  logic [PW-1:0]         ptr_d;
  logic [ADDR_W-1:0]     addr_sel;
  logic [DATA_W-1:0]     wdata_sel;
  logic                  we_sel;

  // The core whose done is pulsing is masked so it cannot win back-to-back.
  assign eligible = bus_io.req & ~bus_io.core_halt & ~done_q;

  dm_arbiter_rr_picker #(
    .NUM_CORES (NUM_CORES)
  ) u_picker (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .any_o      (any),
    .winner_o   (winner)
  );

  assign ptr_d = (winner == PW'(NUM_CORES - 1)) ? '0 : winner + PW'(1);

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (winner == PW'(i)) begin
        addr_sel  = bus_io.addr[i*ADDR_W +: ADDR_W];
        wdata_sel = bus_io.wdata[i*DATA_W +: DATA_W];
        we_sel    = bus_io.we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      is_rd_q      <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      all_halted_q <= 1'b0;
    end else begin
      all_halted_q <= &bus_io.core_halt;
      done_q       <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            win_q       <= winner;
            rr_ptr_q    <= ptr_d;
            gnt_q       <= NUM_CORES'(1) << winner;
            is_rd_q     <= ~we_sel;
            mem_en_q    <= 1'b1;
            mem_we_q    <= we_sel;
            mem_addr_q  <= addr_sel;
            mem_wdata_q <= wdata_sel;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          gnt_q    <= '0;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          done_q <= NUM_CORES'(1) << win_q;
          if (is_rd_q) begin
            rdata_q <= bus_io.mem_rdata;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_io.gnt        = gnt_q;
  assign bus_io.done       = done_q;
  assign bus_io.rdata      = rdata_q;
  assign bus_io.mem_en     = mem_en_q;
  assign bus_io.mem_we     = mem_we_q;
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_wdata  = mem_wdata_q;
  assign bus_io.all_halted = all_halted_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// Randomised bench for dm_arbiter against a transaction-level round-robin/memory model.
`default_nettype none

module tb_dm_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  logic [DW-1:0] mem     [65536];
  logic [DW-1:0] ref_mem [65536];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: phase counts cycles since the grant edge (0 = no access in flight).
  int          m_phase;
  int          m_ptr;
  int          m_cur;
  bit          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd;
  logic [N-1:0]  e_gnt, e_done;
  logic          e_mem_en, e_mem_we, e_allh;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_rdata;

  bit            hold_req;
  int            we_cycles;
  logic [AW-1:0] last_mem_addr;
  int            dut_gq[$];

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_cur = 0; m_we = 1'b0;
    e_gnt = '0; e_done = '0; e_mem_en = 1'b0; e_mem_we = 1'b0; e_allh = 1'b0;
    e_mem_addr = '0; e_mem_wdata = '0; e_rdata = '0;
  endtask

  function automatic bit in_service(input int i);
    return (m_phase != 0) && (m_cur == i);
  endfunction

  task automatic model_advance();
    logic [N-1:0] elig;
    int win;
    elig = bus.req & ~bus.core_halt & ~e_done;
    e_allh = &bus.core_halt;
    e_done = '0;
    if (m_phase == 0) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) begin
        m_cur  = win;
        m_we   = bus.we[win];
        m_addr = bus.addr[win*AW +: AW];
        m_wd   = bus.wdata[win*DW +: DW];
        m_ptr  = (win + 1) % N;
        e_gnt  = N'(1) << win;
        e_mem_en = 1'b1; e_mem_we = m_we;
        e_mem_addr = m_addr; e_mem_wdata = m_wd;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_we) ref_mem[m_addr] = m_wd;
      else      m_rd = ref_mem[m_addr];
      e_gnt = '0; e_mem_en = 1'b0; e_mem_we = 1'b0;
      m_phase = 2;
    end else begin
      e_done = N'(1) << m_cur;
      if (!m_we) e_rdata = m_rd;
      m_phase = 0;
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    chk("gnt", bus.gnt, e_gnt);
    chk("done", bus.done, e_done);
    chk("mem_en", bus.mem_en, e_mem_en);
    chk("mem_we", bus.mem_we, e_mem_we);
    chk("rdata", bus.rdata, e_rdata);
    chk("all_halted", bus.all_halted, e_allh);
    if (e_mem_en) chk("mem_addr", bus.mem_addr, e_mem_addr);
    if (e_mem_we) chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
  endtask

  task automatic step();
    model_advance();
    @(negedge clk);
    check_outputs();
    if (bus.mem_we) we_cycles++;
    if (bus.mem_en) last_mem_addr = bus.mem_addr;
    if (bus.gnt != '0) dut_gq.push_back(oh2idx(bus.gnt));
    if (!hold_req) bus.req = bus.req & ~e_done;
  endtask

  task automatic set_req(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[c] = 1'b1;
    bus.we[c]  = w;
    bus.addr[c*AW +: AW]  = a;
    bus.wdata[c*DW +: DW] = d;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) if (!in_service(i)) bus.req[i] = 1'b0;
    hold_req = 1'b0;
    repeat (4) step();
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (!bus.req[i]) begin
        if ($urandom % 4 == 0)
          set_req(i, 1'($urandom), AW'($urandom % 16), DW'($urandom));
      end else if (!in_service(i) && $urandom % 16 == 0) begin
        bus.req[i] = 1'b0;
      end else if ($urandom % 8 == 0) begin
        bus.addr[i*AW +: AW]  = AW'($urandom % 16);
        bus.wdata[i*DW +: DW] = DW'($urandom);
      end
    end
    if ($urandom % 64 == 0) bus.core_halt = N'($urandom & $urandom);
  endtask

  initial begin
    logic [DW-1:0] old;
    int lat;
    bit seen;
    rst_n = 1'b0;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.core_halt = '0;
    hold_req = 1'b0; we_cycles = 0; last_mem_addr = '0;
    for (int a = 0; a < 65536; a++) begin
      ref_mem[a] = DW'($urandom);
      mem[a]     = ref_mem[a];
    end
    ref_mem[16'h0010] = 16'hBEEF;
    mem[16'h0010]     = 16'hBEEF;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // All cores requesting from reset: strict rotation.
    hold_req = 1'b1;
    bus.req = '1;
    dut_gq.delete();
    repeat (18) step();
    chk("rot_count", 32'(dut_gq.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++)
      chk("rot_order", (k < dut_gq.size()) ? dut_gq[k] : -1, k % 4);
    drain();

    // Single read by core 1.
    set_req(1, 1'b0, 16'h0010, 16'h0000);
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      lat++;
      seen = bus.done[1];
    end
    chk("read_latency", lat, 3);
    chk("read_beef", bus.rdata, 16'hBEEF);
    step();

    // Write then read back by core 2.
    we_cycles = 0;
    set_req(2, 1'b1, 16'h0020, 16'h1234);
    repeat (4) step();
    chk("write_we_cycles", we_cycles, 1);
    set_req(2, 1'b0, 16'h0020, 16'h0000);
    repeat (4) step();
    chk("write_readback", bus.rdata, 16'h1234);

    // Address change after grant is ignored.
    set_req(0, 1'b0, 16'h0005, 16'h0000);
    step();
    bus.addr[0 +: AW] = 16'h0009;
    repeat (3) step();
    chk("addr_captured", last_mem_addr, 16'h0005);
    chk("addr_rdata", bus.rdata, ref_mem[16'h0005]);
    step();

    // Halted cores are skipped; all halted means no grants.
    hold_req = 1'b1;
    bus.core_halt = 4'b0101;
    bus.req = '1;
    repeat (24) step();
    drain();
    bus.core_halt = '1;
    step();
    chk("all_halted_set", bus.all_halted, 1'b1);
    bus.req = '1;
    repeat (6) step();
    bus.req = '0;
    bus.core_halt = '0;
    repeat (2) step();

    repeat (2000) begin
      drive_random();
      step();
    end
    bus.core_halt = '0;
    drain();
    step();

    // Reset during the ACCESS cycle of a write.
    set_req(1, 1'b1, 16'h0030, 16'hA5A5);
    for (int k = 0; k < 4 && !e_mem_we; k++) step();
    chk("rst_reached_access", bus.mem_we, 1'b1);
    old = ref_mem[16'h0030];
    rst_n = 1'b0;
    #1;
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_gnt", bus.gnt, '0);
    model_reset();
    bus.req = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_no_write", mem[16'h0030], old);
    check_outputs();
    rst_n = 1'b1;
    hold_req = 1'b1;
    bus.req = '1;
    dut_gq.delete();
    repeat (3) step();
    chk("rst_ptr_zero", (dut_gq.size() > 0) ? dut_gq[0] : -1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
